// File: rtl/mem_acc_master.sv
// mem_acc_master: buffers client memory requests in a small FIFO and issues them one at a
// time to a controller accessor slot. Define MEM_ACC_WRITE_ACK_EN to return a beat for writes.
module mem_acc_master #(
  parameter int BITSIZE    = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_write_i,
  input  logic [1:0]         req_size_i,
  input  logic [31:0]        req_addr_i,
  input  logic [BITSIZE-1:0] req_data_i,
  output logic               rsp_valid_o,
  input  logic               rsp_ready_i,
  output logic [BITSIZE-1:0] rsp_data_o,
  output logic [31:0]        acc_address_o,
  output logic               acc_write_o,
  output logic [1:0]         acc_write_size_o,
  output logic               acc_read_o,
  output logic [BITSIZE-1:0] acc_data_o,
  input  logic [BITSIZE-1:0] acc_data_i,
  input  logic               acc_done_i
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef struct packed {
    logic               write;
    logic [1:0]         size;
    logic [31:0]        addr;
    logic [BITSIZE-1:0] data;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t state_reg, state_next;

  req_t             fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]   count_reg;

  logic full, empty, push, bypass, fifo_push, pop;
  req_t in_req, head_req, load_req;

  logic [31:0]        addr_reg, addr_next;
  logic [1:0]         size_reg, size_next;
  logic [BITSIZE-1:0] wdata_reg, wdata_next;
  logic [BITSIZE-1:0] rdata_reg, rdata_next;
  logic               read_reg, read_next;
  logic               write_reg, write_next;
  logic               rsp_valid_reg, rsp_valid_next;

  assign full        = (count_reg == DEPTH_C);
  assign empty       = (count_reg == '0);
  assign req_ready_o = !rst_i && !full;
  assign push        = req_valid_i && req_ready_o;
  assign in_req      = {req_write_i, req_size_i, req_addr_i, req_data_i};
  assign head_req    = fifo_mem[rd_ptr_reg];

  // A request arriving while idle and empty skips the FIFO so the strobe rises next cycle.
  assign bypass    = push && empty && (state_reg == IDLE);
  assign pop       = (state_reg == IDLE) && !empty;
  assign fifo_push = push && !bypass;
  assign load_req  = bypass ? in_req : head_req;

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_mem[wr_ptr_reg] <= in_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (fifo_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      if (fifo_push && !pop) begin
        count_reg <= count_reg + CNT_ONE;
      end else if (pop && !fifo_push) begin
        count_reg <= count_reg - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      size_reg      <= '0;
      wdata_reg     <= '0;
      rdata_reg     <= '0;
      read_reg      <= 1'b0;
      write_reg     <= 1'b0;
      rsp_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      size_reg      <= size_next;
      wdata_reg     <= wdata_next;
      rdata_reg     <= rdata_next;
      read_reg      <= read_next;
      write_reg     <= write_next;
      rsp_valid_reg <= rsp_valid_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    size_next      = size_reg;
    wdata_next     = wdata_reg;
    rdata_next     = rdata_reg;
    read_next      = read_reg;
    write_next     = write_reg;
    rsp_valid_next = rsp_valid_reg;
    case (state_reg)
      IDLE: begin
        if (pop || bypass) begin
          addr_next  = load_req.addr;
          size_next  = (load_req.size == 2'b11) ? 2'b10 : load_req.size;
          wdata_next = load_req.write ? load_req.data : '0;
          write_next = load_req.write;
          read_next  = !load_req.write;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (acc_done_i) begin
          read_next  = 1'b0;
          write_next = 1'b0;
          if (read_reg) begin
            rdata_next     = acc_data_i;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
          end else begin
`ifdef MEM_ACC_WRITE_ACK_EN
            rdata_next     = '0;
            rsp_valid_next = 1'b1;
            state_next     = RESP;
`else
            state_next     = IDLE;
`endif
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rsp_valid_o      = rsp_valid_reg;
  assign rsp_data_o       = rdata_reg;
  assign acc_address_o    = addr_reg;
  assign acc_write_o      = write_reg;
  assign acc_read_o       = read_reg;
  assign acc_write_size_o = size_reg;
  assign acc_data_o       = wdata_reg;

endmodule

// File: tb/tb_mem_acc_master.sv
// Bench for mem_acc_master: a request-queue model plus a simple memory controller model,
// checked every cycle, with directed scenarios followed by randomized traffic.
`define CHK(n, a, e) check_eq(n, 128'(a), 128'(e))

module tb_mem_acc_master;

  localparam int DEPTH = 4;
`ifdef MEM_ACC_WRITE_ACK_EN
  localparam int ACK = 1;
`else
  localparam int ACK = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i, req_ready_o, req_write_i;
  logic [1:0]  req_size_i;
  logic [31:0] req_addr_i, req_data_i;
  logic        rsp_valid_o, rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [31:0] acc_address_o;
  logic        acc_write_o, acc_read_o;
  logic [1:0]  acc_write_size_o;
  logic [31:0] acc_data_o, acc_data_i;
  logic        acc_done_i;

  mem_acc_master #(.BITSIZE(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
    .req_size_i(req_size_i), .req_addr_i(req_addr_i), .req_data_i(req_data_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_data_o(rsp_data_o),
    .acc_address_o(acc_address_o), .acc_write_o(acc_write_o),
    .acc_write_size_o(acc_write_size_o), .acc_read_o(acc_read_o),
    .acc_data_o(acc_data_o), .acc_data_i(acc_data_i), .acc_done_i(acc_done_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory behind the controller; unwritten locations read back an address-derived pattern.
  bit [31:0] mem [bit [31:0]];
  function automatic bit [31:0] mem_rd(input bit [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  typedef struct {
    bit        w;
    bit [1:0]  size;
    bit [31:0] addr;
    bit [31:0] data;
  } txn_t;

  txn_t reqq[$];
  txn_t cur;

  int  rsp_mode = 0;   // 0 always ready, 1 never ready, 2 random
  int  fix_lat = 1;    // -1 random latency
  bit  hold_done = 0;
  bit  stray_req = 0;
  bit  rand_stray = 0;

  // Memory-controller model: pulses done after the chosen latency while a strobe is high.
  initial begin
    int cnt, lat;
    bit [31:0] old;
    cnt = 0; lat = 0;
    acc_done_i = 1'b0;
    acc_data_i = '0;
    forever begin
      @(posedge clk); #1;
      acc_done_i = 1'b0;
      if (rst_i) begin
        cnt = 0;
      end else if (acc_read_o || acc_write_o) begin
        if (cnt == 0) lat = (fix_lat >= 0) ? fix_lat : $urandom_range(0, 4);
        if (!hold_done && cnt >= lat) begin
          acc_done_i = 1'b1;
          if (acc_read_o) begin
            acc_data_i = mem_rd(acc_address_o);
          end else begin
            old = mem_rd(acc_address_o);
            case (acc_write_size_o)
              2'b00:   mem[acc_address_o] = {old[31:8], acc_data_o[7:0]};
              2'b01:   mem[acc_address_o] = {old[31:16], acc_data_o[15:0]};
              default: mem[acc_address_o] = acc_data_o;
            endcase
          end
          cnt = 0;
        end else begin
          cnt++;
        end
      end else if (stray_req || (rand_stray && $urandom_range(0, 7) == 0)) begin
        acc_done_i = 1'b1;
        acc_data_i = $urandom;
        stray_req = 1'b0;
      end
    end
  end

  initial begin
    rsp_ready_i = 1'b0;
    forever begin
      @(posedge clk); #2;
      case (rsp_mode)
        0:       rsp_ready_i = 1'b1;
        1:       rsp_ready_i = 1'b0;
        default: rsp_ready_i = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Per-cycle compare against the queue model, using what was seen one cycle earlier.
  logic        p_strobe = 0, p_done = 0, p_rsp_valid = 0, p_rsp_ready = 0, p_rst = 1;
  logic [31:0] p_addr = 0, p_wdata = 0, p_rsp_data = 0;
  logic [1:0]  p_size = 0;

  task automatic check_fields(input string name);
    `CHK({name, "_addr"}, acc_address_o, cur.addr);
    `CHK({name, "_data"}, acc_data_o, cur.w ? cur.data : 32'h0);
    if (cur.w) `CHK({name, "_size"}, acc_write_size_o, (cur.size == 2'b11) ? 2'b10 : cur.size);
  endtask

  always @(negedge clk) begin
    logic strobe;
    logic exp_ready;
    txn_t t;
    strobe = acc_read_o | acc_write_o;
    if (rst_i) begin
      checks++;
      if (req_ready_o !== 1'b0) begin
        failures++;
        $display("FAIL ready_in_reset actual=0x%0h required=0x0", req_ready_o);
      end
      reqq.delete();
      p_strobe = 0; p_done = 0; p_rsp_valid = 0; p_rsp_ready = 0; p_rst = 1;
    end else begin
      checks++;
      if ((acc_read_o & acc_write_o) !== 1'b0) begin
        failures++;
        $display("FAIL one_strobe actual=0x%0h required=0x0", acc_read_o & acc_write_o);
      end
      if (p_strobe) begin
        if (p_done) begin
          `CHK("strobe_drop", strobe, 1'b0);
          if (!cur.w) begin
            `CHK("rsp_valid_rd", rsp_valid_o, 1'b1);
            `CHK("rsp_data_rd", rsp_data_o, mem_rd(cur.addr));
          end else begin
            `CHK("rsp_valid_wr", rsp_valid_o, ACK);
            `CHK("rsp_data_wr", rsp_data_o, (ACK != 0) ? 32'h0 : p_rsp_data);
          end
        end else begin
          `CHK("strobe_hold", {acc_read_o, acc_write_o}, {~cur.w, cur.w});
          check_fields("busy_stable");
        end
      end else if (p_rsp_valid) begin
        if (p_rsp_ready) begin
          `CHK("rsp_taken", {rsp_valid_o, strobe}, 2'b00);
        end else begin
          `CHK("rsp_hold", {rsp_valid_o, strobe}, 2'b10);
          `CHK("rsp_data_hold", rsp_data_o, p_rsp_data);
        end
      end else if (reqq.size() > 0) begin
        cur = reqq.pop_front();
        `CHK("issue_strobe", {acc_read_o, acc_write_o}, {~cur.w, cur.w});
        check_fields("issue");
      end else begin
        `CHK("idle_quiet", {strobe, rsp_valid_o}, 2'b00);
        if (!p_rst)
          `CHK("idle_outputs", {acc_address_o, acc_data_o, acc_write_size_o, rsp_data_o},
               {p_addr, p_wdata, p_size, p_rsp_data});
      end
      if (p_rst)
        `CHK("reset_values", {acc_address_o, acc_data_o, acc_write_size_o, rsp_data_o, rsp_valid_o},
             {32'h0, 32'h0, 2'b00, 32'h0, 1'b0});
      exp_ready = (reqq.size() < DEPTH);
      checks++;
      if (req_ready_o !== exp_ready) begin
        failures++;
        $display("FAIL req_ready actual=0x%0h required=0x%0h", req_ready_o, exp_ready);
      end
      if (req_valid_i && req_ready_o) begin
        t.w = req_write_i; t.size = req_size_i; t.addr = req_addr_i; t.data = req_data_i;
        reqq.push_back(t);
      end
      p_rst = 0;
      p_strobe = strobe;
      p_done = acc_done_i;
      p_rsp_valid = rsp_valid_o;
      p_rsp_ready = rsp_ready_i;
    end
    p_addr = acc_address_o;
    p_wdata = acc_data_o;
    p_size = acc_write_size_o;
    p_rsp_data = rsp_data_o;
  end

  task automatic align();
    @(posedge clk); #1;
  endtask

  task automatic cyc(input int n);
    repeat (n) align();
  endtask

  task automatic send(input bit w, input bit [1:0] sz, input bit [31:0] a, input bit [31:0] d);
    bit acc;
    acc = 0;
    req_valid_i = 1'b1; req_write_i = w; req_size_i = sz; req_addr_i = a; req_data_i = d;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready_o;
      align();
    end
    req_valid_i = 1'b0;
    `CHK("send_accepted", acc, 1'b1);
  endtask

  task automatic wait_rsp(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid_o;
    end
    `CHK(name, ok, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_i = 1'b1;
    req_valid_i = 0; req_write_i = 0; req_size_i = 0; req_addr_i = 0; req_data_i = 0;
    cyc(3);
    rst_i = 1'b0;
    @(negedge clk);
    `CHK("post_reset_ready", req_ready_o, 1'b1);
    `CHK("post_reset_strobes", {acc_read_o, acc_write_o, rsp_valid_o}, 3'b000);
    align();

    // Read at 0x10 holding 0xDEADBEEF, done after 3 cycles, response held off.
    mem[32'h10] = 32'hDEADBEEF; fix_lat = 3; rsp_mode = 1;
    send(1'b0, 2'b10, 32'h10, 32'h0);
    @(negedge clk);
    `CHK("r037_read_strobe", acc_read_o, 1'b1);
    `CHK("r037_addr", acc_address_o, 32'h10);
    wait_rsp("r037_rsp_seen");
    `CHK("r037_rsp_data", rsp_data_o, 32'hDEADBEEF);
    repeat (3) @(negedge clk);
    `CHK("r037_rsp_held", rsp_valid_o, 1'b1);
    align();
    rsp_mode = 0;
    cyc(4);

    // Byte write of 0xA5 at 0x20.
    fix_lat = 2;
    send(1'b1, 2'b00, 32'h20, 32'hA5);
    @(negedge clk);
    `CHK("r038_write_strobe", acc_write_o, 1'b1);
    `CHK("r038_wdata", acc_data_o, 32'hA5);
    `CHK("r038_size", acc_write_size_o, 2'b00);
    n = 0;
    repeat (10) begin
      @(negedge clk);
      if (rsp_valid_o) n++;
    end
    `CHK("r038_ack_beats", n, ACK);
    align();

    // Fill: one in flight plus DEPTH queued, then back-pressure.
    hold_done = 1; fix_lat = 0;
    for (int i = 0; i < 5; i++) send(1'(i), 2'b10, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i));
    @(negedge clk);
    `CHK("r039_full_not_ready", req_ready_o, 1'b0);
    align();
    req_valid_i = 1; req_write_i = 0; req_size_i = 2'b10; req_addr_i = 32'h120; req_data_i = 0;
    repeat (3) begin
      @(negedge clk);
      `CHK("r039_still_full", req_ready_o, 1'b0);
    end
    align();
    hold_done = 0;
    send(1'b0, 2'b10, 32'h120, 32'h0);
    cyc(40);

    // Response held back while more requests queue.
    rsp_mode = 1; fix_lat = 1;
    send(1'b0, 2'b10, 32'h200, 32'h0);
    send(1'b0, 2'b10, 32'h204, 32'h0);
    send(1'b1, 2'b01, 32'h208, 32'hBEEF);
    repeat (10) @(negedge clk);
    `CHK("r040_no_strobe", {acc_read_o, acc_write_o}, 2'b00);
    `CHK("r040_rsp_pending", rsp_valid_o, 1'b1);
    `CHK("r040_queue_ready", req_ready_o, 1'b1);
    align();
    rsp_mode = 0;
    cyc(30);

    // Reset during BUSY, then a late done.
    hold_done = 1;
    send(1'b0, 2'b10, 32'h300, 32'h0);
    send(1'b1, 2'b01, 32'h304, 32'h55);
    cyc(2);
    rst_i = 1'b1;
    cyc(2);
    rst_i = 1'b0; hold_done = 0; stray_req = 1;
    repeat (4) @(negedge clk);
    `CHK("r041_strobes", {acc_read_o, acc_write_o}, 2'b00);
    `CHK("r041_no_rsp", rsp_valid_o, 1'b0);
    `CHK("r041_ready", req_ready_o, 1'b1);
    `CHK("r041_addr_cleared", acc_address_o, 32'h0);
    align();

    // Stray done while idle and empty.
    stray_req = 1;
    cyc(4);

    // Randomized traffic.
    rsp_mode = 2; fix_lat = -1; rand_stray = 1;
    for (int i = 0; i < 300; i++) begin
      cyc($urandom_range(0, 2));
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           32'h400 + 32'(4 * $urandom_range(0, 7)), $urandom);
    end
    rsp_mode = 0; rand_stray = 0;
    cyc(60);
    checks++;
    if (reqq.size() !== 0) begin
      failures++;
      $display("FAIL drained actual=0x%0h required=0x0", reqq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
